// File: rtl/mem_bus_arbiter_if.sv
// Request/response memory bus shared by fetch, load/store and the memory side.
// The master issues a request pulse with mode/addr/wdata/wstrb and receives a
// one-cycle response pulse with data; the slave does the opposite.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  request_enable;
   logic                  mode;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  response_enable;
   logic [DATA_W-1:0]     data;

   modport master (
      output request_enable, mode, addr, wdata, wstrb,
      input  response_enable, data
   );

   modport slave (
      input  request_enable, mode, addr, wdata, wstrb,
      output response_enable, data
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter for the core's single memory bus port.
// Port I (fetch) and port D (load/store) each own one request slot; one
// transaction at a time goes downstream and its response returns to the owner.
module mem_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   mem_bus_arbiter_if.slave  i_bus,
   mem_bus_arbiter_if.slave  d_bus,
   mem_bus_arbiter_if.master m_bus
);
   localparam int STRB_W = DATA_W / 8;

   typedef struct packed {
      logic              mode;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } req_t;

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t            state_q, state_d;
   logic              pend_i_q, pend_d_q;
   req_t              slot_i_q, slot_d_q;
   logic              last_d_q;   // 1: most recent grant went to D
   logic              owner_d_q;  // 1: in-flight transaction belongs to D
   req_t              m_fields_q;
   logic              m_vld_q;
   logic              i_rsp_q, d_rsp_q;
   logic [DATA_W-1:0] i_data_q, d_data_q;

   logic              grant_vld, grant_d, rsp_vld, cap_i, cap_d;
   req_t              i_req_w, d_req_w;

   assign i_req_w = {i_bus.mode, i_bus.addr, i_bus.wdata, i_bus.wstrb};
   assign d_req_w = {d_bus.mode, d_bus.addr, d_bus.wdata, d_bus.wstrb};

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state: grant moves to WAIT, downstream completion returns to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (grant_vld)               state_d = ST_WAIT;
         ST_WAIT: if (m_bus.response_enable)   state_d = ST_IDLE;
         default:                              state_d = ST_IDLE;
      endcase
   end

   // Control decode: grant selection, completion and per-port capture enables
   always_comb begin
      grant_vld = (state_q == ST_IDLE) && (pend_i_q || pend_d_q);
      // D wins only if I is not pending, or on a tie when I had the last grant
      grant_d   = pend_d_q && (!pend_i_q || !last_d_q);
      rsp_vld   = (state_q == ST_WAIT) && m_bus.response_enable;
      // A port with a pending or in-flight request ignores further requests
      cap_i     = i_bus.request_enable && !pend_i_q &&
                  !((state_q == ST_WAIT) && !owner_d_q);
      cap_d     = d_bus.request_enable && !pend_d_q &&
                  !((state_q == ST_WAIT) && owner_d_q);
   end

   // Request capture into the per-port slots
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_i_q <= 1'b0;
         pend_d_q <= 1'b0;
         slot_i_q <= '0;
         slot_d_q <= '0;
      end else begin
         pend_i_q <= (pend_i_q && !(grant_vld && !grant_d)) || cap_i;
         pend_d_q <= (pend_d_q && !(grant_vld && grant_d)) || cap_d;
         if (cap_i) slot_i_q <= i_req_w;
         if (cap_d) slot_d_q <= d_req_w;
      end
   end

   // Downstream issue: one-cycle request pulse, fields hold until next grant
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_vld_q    <= 1'b0;
         m_fields_q <= '0;
         owner_d_q  <= 1'b0;
         last_d_q   <= 1'b1;
      end else begin
         m_vld_q <= grant_vld;
         if (grant_vld) begin
            m_fields_q <= grant_d ? slot_d_q : slot_i_q;
            owner_d_q  <= grant_d;
            last_d_q   <= grant_d;
         end
      end
   end

   // Response routing to the owner; data holds between responses
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         i_rsp_q  <= 1'b0;
         d_rsp_q  <= 1'b0;
         i_data_q <= '0;
         d_data_q <= '0;
      end else begin
         i_rsp_q <= rsp_vld && !owner_d_q;
         d_rsp_q <= rsp_vld && owner_d_q;
         if (rsp_vld && !owner_d_q) i_data_q <= m_bus.data;
         if (rsp_vld && owner_d_q)  d_data_q <= m_bus.data;
      end
   end

   assign m_bus.request_enable  = m_vld_q;
   assign m_bus.mode            = m_fields_q.mode;
   assign m_bus.addr            = m_fields_q.addr;
   assign m_bus.wdata           = m_fields_q.wdata;
   assign m_bus.wstrb           = m_fields_q.wstrb;
   assign i_bus.response_enable = i_rsp_q;
   assign i_bus.data            = i_data_q;
   assign d_bus.response_enable = d_rsp_q;
   assign d_bus.data            = d_data_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_mem_bus_arbiter;
   logic clk;
   logic rstn;
   int   n_tests;
   int   n_fail;

   mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) i_bus ();
   mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) d_bus ();
   mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_bus ();

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .i_bus (i_bus),
      .d_bus (d_bus),
      .m_bus (m_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state (port 0 = I, port 1 = D)
   bit          mdl_pend [2];
   bit          mdl_smode [2];
   logic [31:0] mdl_saddr [2];
   logic [31:0] mdl_swdata [2];
   logic [3:0]  mdl_swstrb [2];
   bit          mdl_busy;
   int          mdl_owner;
   int          mdl_last;
   bit          exp_mreq;
   bit          exp_mmode;
   logic [31:0] exp_maddr;
   logic [31:0] exp_mwdata;
   logic [3:0]  exp_mwstrb;
   bit          exp_resp [2];
   logic [31:0] exp_data [2];

   function automatic logic [135:0] out_vec();
      return {m_bus.request_enable, m_bus.mode, m_bus.addr, m_bus.wdata, m_bus.wstrb,
              i_bus.response_enable, i_bus.data, d_bus.response_enable, d_bus.data};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_bus.request_enable = 0; i_bus.mode = 0; i_bus.addr = 0; i_bus.wdata = 0; i_bus.wstrb = 0;
      d_bus.request_enable = 0; d_bus.mode = 0; d_bus.addr = 0; d_bus.wdata = 0; d_bus.wstrb = 0;
      m_bus.response_enable = 0; m_bus.data = 0;
   endtask

   task automatic apply_reset();
      rstn = 0;
      clear_inputs();
      tick();
      tick();
      rstn = 1;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      rstn = 1;
      #2;
      rstn = 0;
      #1;
      n_tests++;
      if (out_vec() !== '0) begin
         n_fail++; $display("FAIL reset_async_outputs: got %h want 0", out_vec());
      end
      i_bus.request_enable = 1; i_bus.addr = 32'h40;
      tick();
      tick();
      n_tests++;
      if (out_vec() !== '0) begin
         n_fail++; $display("FAIL reset_held_outputs: got %h want 0", out_vec());
      end
      clear_inputs();
      rstn = 1;
      tick();
      tick();
      n_tests++;
      if (m_bus.request_enable !== 1'b0) begin
         n_fail++; $display("FAIL reset_no_issue: m_req got %b want 0", m_bus.request_enable);
      end
   endtask

   task automatic test_single_fetch();
      apply_reset();
      i_bus.request_enable = 1; i_bus.mode = 0; i_bus.addr = 32'h100;
      tick();
      i_bus.request_enable = 0;
      n_tests++;
      if (m_bus.request_enable !== 1'b0) begin
         n_fail++; $display("FAIL single_no_early_issue: m_req got %b want 0", m_bus.request_enable);
      end
      tick();
      n_tests++;
      if (m_bus.request_enable !== 1'b1 || m_bus.addr !== 32'h100 || m_bus.mode !== 1'b0) begin
         n_fail++; $display("FAIL single_issue: req=%b addr=%h mode=%b want 1 00000100 0",
                            m_bus.request_enable, m_bus.addr, m_bus.mode);
      end
      tick();
      n_tests++;
      if (m_bus.request_enable !== 1'b0 || m_bus.addr !== 32'h100) begin
         n_fail++; $display("FAIL single_pulse_hold: req=%b addr=%h want 0 00000100",
                            m_bus.request_enable, m_bus.addr);
      end
      tick();
      m_bus.response_enable = 1; m_bus.data = 32'hDEADBEEF;
      tick();
      m_bus.response_enable = 0;
      n_tests++;
      if (i_bus.response_enable !== 1'b1 || i_bus.data !== 32'hDEADBEEF || d_bus.response_enable !== 1'b0) begin
         n_fail++; $display("FAIL single_response: i_resp=%b i_data=%h d_resp=%b want 1 deadbeef 0",
                            i_bus.response_enable, i_bus.data, d_bus.response_enable);
      end
      tick();
      n_tests++;
      if (i_bus.response_enable !== 1'b0 || i_bus.data !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL single_data_hold: i_resp=%b i_data=%h want 0 deadbeef",
                            i_bus.response_enable, i_bus.data);
      end
   endtask

   task automatic test_duplicate();
      int extra;
      apply_reset();
      i_bus.request_enable = 1; i_bus.addr = 32'h100;
      tick();
      i_bus.request_enable = 0;
      tick();
      i_bus.request_enable = 1; i_bus.addr = 32'h300;
      tick();
      i_bus.request_enable = 0;
      m_bus.response_enable = 1; m_bus.data = 32'h0000_1111;
      tick();
      m_bus.response_enable = 0;
      n_tests++;
      if (i_bus.response_enable !== 1'b1) begin
         n_fail++; $display("FAIL dup_first_response: i_resp got %b want 1", i_bus.response_enable);
      end
      extra = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (m_bus.request_enable === 1'b1) extra++;
      end
      n_tests++;
      if (extra !== 0 || m_bus.addr !== 32'h100) begin
         n_fail++; $display("FAIL dup_dropped: extra issues=%0d addr=%h want 0 00000100", extra, m_bus.addr);
      end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      i_bus.request_enable = 1; i_bus.mode = 0; i_bus.addr = 32'h200;
      d_bus.request_enable = 1; d_bus.mode = 1; d_bus.addr = 32'h8000;
      d_bus.wdata = 32'h12345678; d_bus.wstrb = 4'hF;
      tick();
      clear_inputs();
      tick();
      n_tests++;
      if (m_bus.request_enable !== 1'b1 || m_bus.addr !== 32'h200 || m_bus.mode !== 1'b0) begin
         n_fail++; $display("FAIL simul_first_grant_i: req=%b addr=%h mode=%b want 1 00000200 0",
                            m_bus.request_enable, m_bus.addr, m_bus.mode);
      end
      m_bus.response_enable = 1; m_bus.data = 32'hA5A5_0001;
      tick();
      m_bus.response_enable = 0;
      n_tests++;
      if (i_bus.response_enable !== 1'b1 || m_bus.request_enable !== 1'b0) begin
         n_fail++; $display("FAIL simul_idle_gap: i_resp=%b m_req=%b want 1 0",
                            i_bus.response_enable, m_bus.request_enable);
      end
      tick();
      n_tests++;
      if (m_bus.request_enable !== 1'b1 || m_bus.addr !== 32'h8000 || m_bus.mode !== 1'b1 ||
          m_bus.wstrb !== 4'hF || m_bus.wdata !== 32'h12345678) begin
         n_fail++; $display("FAIL simul_second_grant_d: req=%b addr=%h mode=%b wstrb=%h wdata=%h want 1 00008000 1 f 12345678",
                            m_bus.request_enable, m_bus.addr, m_bus.mode, m_bus.wstrb, m_bus.wdata);
      end
      m_bus.response_enable = 1; m_bus.data = 32'h0000_0077;
      tick();
      m_bus.response_enable = 0;
      n_tests++;
      if (d_bus.response_enable !== 1'b1 || i_bus.response_enable !== 1'b0 || d_bus.data !== 32'h77) begin
         n_fail++; $display("FAIL simul_write_response: d_resp=%b i_resp=%b d_data=%h want 1 0 00000077",
                            d_bus.response_enable, i_bus.response_enable, d_bus.data);
      end
   endtask

   task automatic test_fairness();
      int  waited;
      int  port;
      apply_reset();
      i_bus.request_enable = 1; i_bus.mode = 0; i_bus.addr = 32'h1000;
      d_bus.request_enable = 1; d_bus.mode = 1; d_bus.addr = 32'h2000; d_bus.wstrb = 4'h3;
      for (int k = 0; k < 6; k++) begin
         port = k % 2;
         waited = 0;
         do begin
            tick();
            waited++;
         end while (m_bus.request_enable !== 1'b1 && waited < 20);
         n_tests++;
         if (m_bus.request_enable !== 1'b1) begin
            n_fail++; $display("FAIL fair_timeout_%0d: no downstream request within 20 cycles", k);
            break;
         end
         n_tests++;
         if (m_bus.addr !== (port == 1 ? 32'h2000 : 32'h1000)) begin
            n_fail++; $display("FAIL fair_grant_%0d: addr=%h want %h", k, m_bus.addr,
                               (port == 1 ? 32'h2000 : 32'h1000));
         end
         m_bus.response_enable = 1; m_bus.data = 32'hF000 + k;
         tick();
         m_bus.response_enable = 0;
         n_tests++;
         if ({i_bus.response_enable, d_bus.response_enable} !== (port == 1 ? 2'b01 : 2'b10)) begin
            n_fail++; $display("FAIL fair_route_%0d: {i,d} resp=%b%b want %b", k,
                               i_bus.response_enable, d_bus.response_enable, (port == 1 ? 2'b01 : 2'b10));
         end
      end
      clear_inputs();
   endtask

   task automatic test_stray_response();
      apply_reset();
      m_bus.response_enable = 1; m_bus.data = 32'h5555_5555;
      tick();
      m_bus.response_enable = 0;
      n_tests++;
      if (i_bus.response_enable !== 1'b0 || d_bus.response_enable !== 1'b0 ||
          i_bus.data !== 32'h0 || d_bus.data !== 32'h0) begin
         n_fail++; $display("FAIL stray_ignored: i_resp=%b d_resp=%b i_data=%h d_data=%h want 0 0 0 0",
                            i_bus.response_enable, d_bus.response_enable, i_bus.data, d_bus.data);
      end
      i_bus.request_enable = 1; i_bus.addr = 32'h400;
      tick();
      i_bus.request_enable = 0;
      tick();
      n_tests++;
      if (m_bus.request_enable !== 1'b1 || m_bus.addr !== 32'h400) begin
         n_fail++; $display("FAIL stray_still_idle: req=%b addr=%h want 1 00000400",
                            m_bus.request_enable, m_bus.addr);
      end
      m_bus.response_enable = 1;
      tick();
      m_bus.response_enable = 0;
   endtask

   task automatic test_async_reset();
      int issued;
      apply_reset();
      i_bus.request_enable = 1; i_bus.addr = 32'h100;
      tick();
      i_bus.request_enable = 0;
      d_bus.request_enable = 1; d_bus.mode = 1; d_bus.addr = 32'h500; d_bus.wstrb = 4'hF;
      tick();
      d_bus.request_enable = 0;
      n_tests++;
      if (m_bus.request_enable !== 1'b1) begin
         n_fail++; $display("FAIL areset_setup: m_req got %b want 1", m_bus.request_enable);
      end
      #2;
      rstn = 0;
      #1;
      n_tests++;
      if (out_vec() !== '0) begin
         n_fail++; $display("FAIL areset_immediate: got %h want 0", out_vec());
      end
      tick();
      rstn = 1;
      m_bus.response_enable = 1; m_bus.data = 32'hBAD0_BAD0;
      tick();
      m_bus.response_enable = 0;
      n_tests++;
      if (i_bus.response_enable !== 1'b0 || d_bus.response_enable !== 1'b0 || i_bus.data !== 32'h0) begin
         n_fail++; $display("FAIL areset_late_resp: i_resp=%b d_resp=%b i_data=%h want 0 0 0",
                            i_bus.response_enable, d_bus.response_enable, i_bus.data);
      end
      issued = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (m_bus.request_enable === 1'b1) issued++;
      end
      n_tests++;
      if (issued !== 0) begin
         n_fail++; $display("FAIL areset_pending_dropped: issued=%0d want 0", issued);
      end
   endtask

   task automatic test_random();
      bit          req [2];
      bit          rmode [2];
      logic [31:0] raddr [2];
      logic [31:0] rwdata [2];
      logic [3:0]  rwstrb [2];
      bit          mresp;
      logic [31:0] mdata;
      int          mem_cnt;
      int          win;
      bit          busy_old;
      int          owner_old;
      apply_reset();
      for (int p = 0; p < 2; p++) begin
         mdl_pend[p] = 0; mdl_smode[p] = 0; mdl_saddr[p] = 0; mdl_swdata[p] = 0; mdl_swstrb[p] = 0;
         exp_resp[p] = 0; exp_data[p] = 0;
      end
      mdl_busy = 0; mdl_owner = 0; mdl_last = 1;
      exp_mreq = 0; exp_mmode = 0; exp_maddr = 0; exp_mwdata = 0; exp_mwstrb = 0;
      mem_cnt = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         n_tests++;
         if ({m_bus.request_enable, m_bus.mode, m_bus.addr, m_bus.wdata, m_bus.wstrb} !==
             {exp_mreq, exp_mmode, exp_maddr, exp_mwdata, exp_mwstrb}) begin
            n_fail++; $display("FAIL rand_m_bus cyc %0d: got %b %b %h %h %h want %b %b %h %h %h", cyc,
                               m_bus.request_enable, m_bus.mode, m_bus.addr, m_bus.wdata, m_bus.wstrb,
                               exp_mreq, exp_mmode, exp_maddr, exp_mwdata, exp_mwstrb);
         end
         n_tests++;
         if ({i_bus.response_enable, i_bus.data, d_bus.response_enable, d_bus.data} !==
             {exp_resp[0], exp_data[0], exp_resp[1], exp_data[1]}) begin
            n_fail++; $display("FAIL rand_resp cyc %0d: i %b %h d %b %h want i %b %h d %b %h", cyc,
                               i_bus.response_enable, i_bus.data, d_bus.response_enable, d_bus.data,
                               exp_resp[0], exp_data[0], exp_resp[1], exp_data[1]);
         end
         // Stimulus for the next edge
         if (exp_mreq) mem_cnt = $urandom_range(0, 3);
         for (int p = 0; p < 2; p++) begin
            req[p]    = ($urandom_range(0, 2) == 0);
            rmode[p]  = $urandom_range(0, 1);
            raddr[p]  = $urandom;
            rwdata[p] = $urandom;
            rwstrb[p] = $urandom_range(0, 15);
         end
         mdata = $urandom;
         if (mdl_busy) begin
            mresp = (mem_cnt == 0);
            if (mem_cnt != 0) mem_cnt--;
         end else begin
            mresp = ($urandom_range(0, 7) == 0);
         end
         i_bus.request_enable = req[0]; i_bus.mode = rmode[0]; i_bus.addr = raddr[0];
         i_bus.wdata = rwdata[0]; i_bus.wstrb = rwstrb[0];
         d_bus.request_enable = req[1]; d_bus.mode = rmode[1]; d_bus.addr = raddr[1];
         d_bus.wdata = rwdata[1]; d_bus.wstrb = rwstrb[1];
         m_bus.response_enable = mresp; m_bus.data = mdata;
         // Model: what the outputs must be after this edge
         busy_old  = mdl_busy;
         owner_old = mdl_owner;
         exp_mreq = 0;
         exp_resp[0] = 0;
         exp_resp[1] = 0;
         win = -1;
         if (busy_old) begin
            if (mresp) begin
               exp_resp[owner_old] = 1;
               exp_data[owner_old] = mdata;
               mdl_busy = 0;
            end
         end else if (mdl_pend[0] || mdl_pend[1]) begin
            if (mdl_pend[0] && mdl_pend[1]) win = 1 - mdl_last;
            else                            win = mdl_pend[0] ? 0 : 1;
            exp_mreq   = 1;
            exp_mmode  = mdl_smode[win];
            exp_maddr  = mdl_saddr[win];
            exp_mwdata = mdl_swdata[win];
            exp_mwstrb = mdl_swstrb[win];
         end
         for (int p = 0; p < 2; p++) begin
            if (req[p] && !mdl_pend[p] && !(busy_old && owner_old == p)) begin
               mdl_pend[p] = 1;
               mdl_smode[p] = rmode[p]; mdl_saddr[p] = raddr[p];
               mdl_swdata[p] = rwdata[p]; mdl_swstrb[p] = rwstrb[p];
            end
         end
         if (win >= 0) begin
            mdl_pend[win] = 0;
            mdl_owner = win;
            mdl_last = win;
            mdl_busy = 1;
         end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_single_fetch();
      test_duplicate();
      test_simultaneous();
      test_fairness();
      test_stray_response();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
